serial_rx_ctrl: RTL and testbench

- Serial receive front end: synchronises a UART-style serial line, detects the start bit, times bit periods, shifts in a data frame LSB-first, checks the stop bit, and buffers the byte for the consumer.
- Sits directly upstream of the byte consumer. Bit-period timing and bit counting are handled by flex_counter instances, driven through their clear/count_enable inputs and read back through count_out/rollover_flag.

---
 rtl/serial_rx_pkg.sv | 22 ++
 rtl/flex_counter.sv | 36 +++
 rtl/rx_bit_timer.sv | 53 +++++
 rtl/serial_rx_ctrl.sv | 151 +++++++++++++++
 tb/tb_serial_rx_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared state encoding, defaults and helpers for the serial receiver
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        RECEIVE,
        PARITY_CHK,
        STOP_CHK,
        LOAD
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 10;
    localparam int DEFAULT_DATA_BITS    = 8;

    localparam logic IDLE_LINE = 1'b1;

    function automatic logic even_parity(input logic [7:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - clearable up-counter that wraps from rollover_val back to 1
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] next_count;

    always_comb begin
        next_count = count_out;
        if (clear) begin
            next_count = '0;
        end else if (count_enable) begin
            next_count = (count_out == rollover_val) ? NUM_CNT_BITS'(1)
                                                     : count_out + NUM_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= next_count;
            rollover_flag <= (next_count == rollover_val);
        end
    end

endmodule

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - bit-period timer and data-bit counter for the serial receiver
module rx_bit_timer
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic clk,
    input  logic n_rst,
    input  logic timer_clear,
    input  logic timer_enable,
    input  logic bit_enable,
    output logic sample_strobe,
    output logic data_done
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    // Cleared to 0 on the detect cycle, so the first mid-bit lands at count C/2-1;
    // the 1..C wrap keeps every later sample exactly one period apart.
    localparam logic [TW-1:0] MID_COUNT   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] AFTER_MID   = TW'(CLKS_PER_BIT / 2);

    logic [TW-1:0] timer_count;
    logic          timer_roll_unused;
    logic [BW-1:0] bit_count_unused;
    logic          bits_full;

    flex_counter #(.NUM_CNT_BITS(TW)) u_period (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (timer_clear),
        .count_enable (timer_enable),
        .rollover_val (TW'(CLKS_PER_BIT)),
        .count_out    (timer_count),
        .rollover_flag(timer_roll_unused)
    );

    flex_counter #(.NUM_CNT_BITS(BW)) u_bits (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (timer_clear),
        .count_enable (bit_enable),
        .rollover_val (BW'(DATA_BITS)),
        .count_out    (bit_count_unused),
        .rollover_flag(bits_full)
    );

    assign sample_strobe = timer_enable && (timer_count == MID_COUNT);
    // bits_full stays high until the next clear; qualify it to a single-cycle pulse.
    assign data_done     = bits_full && (timer_count == AFTER_MID);

endmodule

// File: rtl/serial_rx_ctrl.sv
// rtl/serial_rx_ctrl.sv - UART-style receiver: synchroniser, frame FSM, shift register, byte buffer
// Define SERIAL_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module serial_rx_ctrl
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error,
    output logic                 parity_error
);

    rx_state_t            state;
    logic                 sync_1, sync_2, sync_prev;
    logic                 start_edge, timer_enable, bit_enable;
    logic                 sample_strobe, data_done;
    logic [DATA_BITS-1:0] shift_reg, shift_next;

`ifdef SERIAL_RX_PARITY_EN
    logic parity_bad, parity_q;
    assign parity_error = parity_q;
`else
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_1    <= IDLE_LINE;
            sync_2    <= IDLE_LINE;
            sync_prev <= IDLE_LINE;
        end else begin
            sync_1    <= serial_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign start_edge   = (state == IDLE) && (sync_2 != IDLE_LINE) && (sync_prev == IDLE_LINE);
    assign timer_enable = (state == START_CHK) || (state == RECEIVE) ||
                          (state == PARITY_CHK) || (state == STOP_CHK);
    assign bit_enable   = (state == RECEIVE) && sample_strobe;

    always_comb begin
        shift_next                = shift_reg >> 1;
        shift_next[DATA_BITS-1]   = sync_2;
    end

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_BITS   (DATA_BITS)
    ) u_bit_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .timer_clear  (start_edge),
        .timer_enable (timer_enable),
        .bit_enable   (bit_enable),
        .sample_strobe(sample_strobe),
        .data_done    (data_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            shift_reg     <= '0;
            rx_data       <= '1;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_bad    <= 1'b0;
            parity_q      <= 1'b0;
`endif
        end else begin
            // LOAD below overrides this when the read and the load coincide.
            if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state         <= START_CHK;
                        framing_error <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
                        parity_q      <= 1'b0;
`endif
                    end
                end
                START_CHK: begin
                    if (sample_strobe) begin
                        state <= (sync_2 == IDLE_LINE) ? IDLE : RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (bit_enable) begin
                        shift_reg <= shift_next;
                    end
                    if (data_done) begin
`ifdef SERIAL_RX_PARITY_EN
                        state <= PARITY_CHK;
`else
                        state <= STOP_CHK;
`endif
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY_CHK: begin
                    if (sample_strobe) begin
                        parity_bad <= (sync_2 != even_parity(8'(shift_reg)));
                        state      <= STOP_CHK;
                    end
                end
`endif
                STOP_CHK: begin
                    if (sample_strobe) begin
                        if (sync_2 != IDLE_LINE) begin
                            framing_error <= 1'b1;
                            state         <= IDLE;
                        end
`ifdef SERIAL_RX_PARITY_EN
                        else if (parity_bad) begin
                            parity_q <= 1'b1;
                            state    <= IDLE;
                        end
`endif
                        else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    rx_data    <= shift_reg;
                    data_ready <= 1'b1;
                    if (data_ready && !data_read) begin
                        overrun_error <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// tb/tb_serial_rx_ctrl.sv - scoreboard bench for serial_rx_ctrl (SERIAL_RX_PARITY_EN aware)
module tb_serial_rx_ctrl;

    localparam int C  = 10;
    localparam int DB = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Offset from the detect cycle to the final (stop) sample.
    localparam int LAST_SAMPLE = (DB + 1 + PB) * C + C / 2;

    typedef struct {
        logic [7:0] data;
        logic       ready;
        logic       ovr;
        logic       fe;
        logic       pe;
        int         at;
    } exp_t;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       serial_in;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready, overrun_error, framing_error, parity_error;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    logic [7:0] m_data  = 8'hFF;
    logic       m_ready = 1'b0;
    logic       m_ovr   = 1'b0;

    logic [7:0] p_data  = 8'hFF;
    logic       p_ready = 1'b0, p_ovr = 1'b0, p_fe = 1'b0, p_pe = 1'b0;

    serial_rx_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
        .clk          (tb_clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .data_read    (data_read),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .overrun_error(overrun_error),
        .framing_error(framing_error),
        .parity_error (parity_error)
    );

    always #5 tb_clk = ~tb_clk;
    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: any new byte or new error flag is an output event to be matched.
    always @(negedge tb_clk) begin
        exp_t e;
        logic ev;
        if (n_rst === 1'b1) begin
            ev = (data_ready && !p_ready) || (overrun_error && !p_ovr) ||
                 (data_ready && p_ready && rx_data != p_data) ||
                 (framing_error && !p_fe) || (parity_error && !p_pe);
            if (ev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: rx_data %0h ready %0b fe %0b pe %0b at cycle %0d, none expected",
                             rx_data, data_ready, framing_error, parity_error, cyc);
                end else begin
                    e = sb.pop_front();
                    check("rx_data",       32'(rx_data),       32'(e.data));
                    check("data_ready",    32'(data_ready),    32'(e.ready));
                    check("overrun_error", 32'(overrun_error), 32'(e.ovr));
                    check("framing_error", 32'(framing_error), 32'(e.fe));
                    check("parity_error",  32'(parity_error),  32'(e.pe));
                    check("output_cycle",  32'(cyc),           32'(e.at));
                end
            end else if (sb.size() != 0 && cyc > sb[0].at) begin
                e = sb.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_output: nothing seen by cycle %0d, expected at cycle %0d", cyc, e.at);
            end
        end
        p_data  = rx_data;
        p_ready = data_ready;
        p_ovr   = overrun_error;
        p_fe    = framing_error;
        p_pe    = parity_error;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge tb_clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"},    32'(rx_data),       32'h0000_00FF);
        check({tag, "_ready"},      32'(data_ready),    32'd0);
        check({tag, "_overrun"},    32'(overrun_error), 32'd0);
        check({tag, "_framing"},    32'(framing_error), 32'd0);
        check({tag, "_parity"},     32'(parity_error),  32'd0);
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        tick(1);
        data_read = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        check("ready_after_read",   32'(data_ready),    32'(m_ready));
        check("overrun_after_read", 32'(overrun_error), 32'(m_ovr));
    endtask

    task automatic pulse_read_at(input int t);
        while (cyc < t) tick(1);
        data_read = 1'b1;
        tick(1);
        data_read = 1'b0;
    endtask

    // Caller is 1 time unit after a rising edge; the start bit goes out immediately.
    task automatic send_frame(input logic [7:0] b, input bit stop_bad, input bit par_bad,
                              input int abort_bits, input bit read_in_load, input bit chk_clear);
        logic [11:0] bits;
        int          nb, d;
        exp_t        e;
        d  = cyc + 2;
        nb = DB + 2 + PB;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[i + 1] = b[i];
        if (PB == 1) bits[DB + 1] = (^b) ^ par_bad;
        bits[nb - 1] = !stop_bad;
        if (abort_bits == 0) begin
            e.data  = m_data;
            e.ready = m_ready;
            e.ovr   = m_ovr;
            e.fe    = 1'b0;
            e.pe    = 1'b0;
            e.at    = d + LAST_SAMPLE + 1;
            if (stop_bad) begin
                e.fe = 1'b1;
            end else if (par_bad && PB == 1) begin
                e.pe = 1'b1;
            end else begin
                e.data  = b;
                e.ready = 1'b1;
                e.ovr   = m_ready && !read_in_load;
                e.at    = d + LAST_SAMPLE + 2;
                m_data  = b;
                m_ready = 1'b1;
                m_ovr   = e.ovr;
            end
            sb.push_back(e);
        end
        for (int k = 0; k < nb; k++) begin
            serial_in = bits[k];
            if (abort_bits != 0 && k == abort_bits + 1) begin
                serial_in = 1'b1;
                n_rst = 1'b0;
                #1;
                check_reset_outputs("midframe_reset");
                m_data  = 8'hFF;
                m_ready = 1'b0;
                m_ovr   = 1'b0;
                tick(1);
                n_rst = 1'b1;
                tick(C);
                return;
            end
            for (int c = 0; c < C; c++) begin
                if (chk_clear && k == 0 && c == 5) begin
                    check("framing_clear_on_start", 32'(framing_error), 32'd0);
                    check("parity_clear_on_start",  32'(parity_error),  32'd0);
                end
                tick(1);
            end
        end
        serial_in = 1'b1;
        tick(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        n_rst     = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
        tick(3);
        n_rst = 1'b1;
        tick(20);
        check_reset_outputs("reset");

        send_frame(8'hA5, 0, 0, 0, 0, 1);
        pulse_read();

        // Short low glitch must be rejected at the start-bit sample.
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        tick(20);
        check("glitch_ready",   32'(data_ready),    32'd0);
        check("glitch_framing", 32'(framing_error), 32'd0);
        send_frame(8'h3C, 0, 0, 0, 0, 1);
        pulse_read();

        send_frame(8'h55, 1, 0, 0, 0, 1);
        send_frame(8'h5A, 0, 0, 0, 0, 1);
        pulse_read();

        send_frame(8'h11, 0, 0, 0, 0, 1);
        send_frame(8'h22, 0, 0, 0, 0, 1);
        pulse_read();

        // Read in the LOAD cycle: the load wins and no overrun is raised.
        send_frame(8'h33, 0, 0, 0, 0, 1);
        t = cyc + 2 + LAST_SAMPLE + 1;
        fork
            send_frame(8'h44, 0, 0, 0, 1, 1);
            pulse_read_at(t);
        join
        pulse_read();

        send_frame(8'hF0, 0, 0, 4, 0, 0);
        send_frame(8'h0F, 0, 0, 0, 0, 1);
        pulse_read();

`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h07, 0, 1, 0, 0, 1);
        send_frame(8'h07, 1, 1, 0, 0, 1);
        send_frame(8'h07, 0, 0, 0, 0, 1);
        pulse_read();
`endif

        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            bit         sbad, pbad;
            b    = 8'($urandom_range(0, 255));
            sbad = ($urandom_range(0, 5) == 0);
            pbad = ($urandom_range(0, 5) == 0);
            send_frame(b, sbad, pbad, 0, 0, 1);
            if (m_ovr || $urandom_range(0, 2) != 0) pulse_read();
            tick($urandom_range(0, 4));
        end

        tick(40);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
